// File: rtl/me_pkg.sv
// Shared types for the macroblock scheduler: FSM states, result record and
// frame-to-macroblock count helpers.
package me_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DRAIN
    } me_state_t;

    typedef struct packed {
        logic [7:0]        col;
        logic [7:0]        row;
        logic signed [5:0] mv_x;
        logic signed [5:0] mv_y;
        logic [15:0]       sad;
    } me_result_t;

    function automatic int mb_cols(input int frame_width, input int mb_size);
        return frame_width / mb_size;
    endfunction

    function automatic int mb_rows(input int frame_height, input int mb_size);
        return frame_height / mb_size;
    endfunction

endpackage

// File: rtl/me_result_fifo.sv
// Synchronous result FIFO between the ME engine capture point and the MV writer.
// Head data reads as zero while empty so the result outputs stay clean.
module me_result_fifo
    import me_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  me_result_t    push_data,
    input  logic          pop,
    output me_result_t    head,
    output logic          empty,
    output logic [CW-1:0] count
);

    me_result_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign do_push = push && (count != CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/me_mb_scheduler.sv
// Frame-level macroblock scheduler for the hexbs_top ME engine.
// Optional per-frame SAD accumulator enabled by ME_SAD_ACCUM_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for frame_go
// S_ISSUE | current MB ready; start engine once the FIFO has a free slot
// S_WAIT  | engine busy on current MB; capture result on me_done
// S_DRAIN | all MBs issued; wait for the consumer to empty the FIFO
module me_mb_scheduler
    import me_pkg::*;
#(
    parameter int FRAME_WIDTH  = 352,
    parameter int FRAME_HEIGHT = 240,
    parameter int MB_SIZE      = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_go,
    input  logic [31:0]       frame_start_addr,
    output logic              busy,
    output logic              frame_done,
    output logic              me_start,
    output logic [31:0]       me_frame_start_addr,
    output logic [31:0]       me_mb_x,
    output logic [31:0]       me_mb_y,
    input  logic signed [5:0] me_mv_x,
    input  logic signed [5:0] me_mv_y,
    input  logic [15:0]       me_sad,
    input  logic              me_done,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [7:0]        res_mb_col,
    output logic [7:0]        res_mb_row,
    output logic signed [5:0] res_mv_x,
    output logic signed [5:0] res_mv_y,
    output logic [15:0]       res_sad
`ifdef ME_SAD_ACCUM_EN
    ,
    output logic [31:0]       frame_sad
`endif
);

    localparam int MBC = mb_cols(FRAME_WIDTH, MB_SIZE);
    localparam int MBR = mb_rows(FRAME_HEIGHT, MB_SIZE);
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;

    me_state_t     state;
    me_state_t     state_nx;
    logic [7:0]    col;
    logic [7:0]    row;
    logic [31:0]   addr;
    logic          accept;
    logic          push;
    logic          done_nx;
    logic          last_mb;
    logic          room;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    me_result_t    push_data;
    me_result_t    head;

    assign room    = (fifo_count < CW'(FIFO_DEPTH));
    assign last_mb = (col == 8'(MBC - 1)) && (row == 8'(MBR - 1));

    always_comb begin
        state_nx = state;
        me_start = 1'b0;
        accept   = 1'b0;
        push     = 1'b0;
        done_nx  = 1'b0;
        case (state)
            S_IDLE: begin
                if (frame_go) begin
                    accept   = 1'b1;
                    state_nx = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Slot is reserved at issue time so the later capture can never overflow.
                if (room) begin
                    me_start = 1'b1;
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                if (me_done) begin
                    push     = 1'b1;
                    state_nx = last_mb ? S_DRAIN : S_ISSUE;
                end
            end
            S_DRAIN: begin
                if (fifo_empty) begin
                    done_nx  = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            col        <= '0;
            row        <= '0;
            addr       <= '0;
            frame_done <= 1'b0;
`ifdef ME_SAD_ACCUM_EN
            frame_sad  <= '0;
`endif
        end else begin
            state      <= state_nx;
            frame_done <= done_nx;
            if (accept) begin
                addr <= frame_start_addr;
                col  <= '0;
                row  <= '0;
            end else if (push && !last_mb) begin
                if (col == 8'(MBC - 1)) begin
                    col <= '0;
                    row <= row + 8'd1;
                end else begin
                    col <= col + 8'd1;
                end
            end
`ifdef ME_SAD_ACCUM_EN
            if (accept) begin
                frame_sad <= '0;
            end else if (push) begin
                frame_sad <= frame_sad + {16'd0, me_sad};
            end
`endif
        end
    end

    assign busy                = (state != S_IDLE);
    assign me_frame_start_addr = addr;
    assign me_mb_x             = 32'(col) * 32'(MB_SIZE);
    assign me_mb_y             = 32'(row) * 32'(MB_SIZE);

    assign push_data = '{col: col, row: row, mv_x: me_mv_x, mv_y: me_mv_y, sad: me_sad};

    me_result_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data(push_data),
        .pop      (res_valid && res_ready),
        .head     (head),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign res_valid  = !fifo_empty;
    assign res_mb_col = head.col;
    assign res_mb_row = head.row;
    assign res_mv_x   = head.mv_x;
    assign res_mv_y   = head.mv_y;
    assign res_sad    = head.sad;

endmodule
